// File: rtl/cycle_ctrl_pkg.sv
// Shared constants for the cycle controller: state encodings,
// counter widths and the legal divider range.
package cycle_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam int CYCLES_W = 32;
  localparam int DIV_MIN  = 1;
  localparam int DIV_MAX  = 255;
  localparam int DIV_W    = 8;

  // Keep an out-of-range DIV from producing a nonsense terminal count.
  function automatic int clamp_div(input int div);
    if (div < DIV_MIN)
      return DIV_MIN;
    else if (div > DIV_MAX)
      return DIV_MAX;
    else
      return div;
  endfunction

endpackage

// File: rtl/cycle_controller_divider.sv
// clk_divider: counts 0..DIV-1 while enabled; tick marks the
// terminal count. Counter is held at zero while clear is high.
module clk_divider
  import cycle_ctrl_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int DIV_EFF = clamp_div(DIV);
  localparam logic [DIV_W-1:0] TOP = DIV_W'(DIV_EFF - 1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == TOP)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TOP);

endmodule

// File: rtl/cycle_controller.sv
// Run/step/halt sequencer producing the datapath clock enable.
// Optional cycle limit is compiled in with CYCLE_LIMIT_EN.
module cycle_controller
  import cycle_ctrl_pkg::*;
#(
  parameter int DIV        = 1,
  parameter int MAX_CYCLES = 1000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                RUN,
  input  logic                STEP,
  input  logic                HALT_REQ,
  output logic                CE,
  output logic [CYCLES_W-1:0] CYCLES,
  output logic [1:0]          STATE,
  output logic                HALTED
);

`ifdef CYCLE_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  localparam logic [CYCLES_W-1:0] LIMIT_LAST =
    CYCLES_W'(MAX_CYCLES - 1);

  logic [1:0]          state;
  logic [1:0]          state_d;
  logic                step_prev;
  logic                step_edge;
  logic                div_tick;
  logic                ce;
  logic                limit_hit;
  logic [CYCLES_W-1:0] cycles_q;

  clk_divider #(
    .DIV(DIV)
  ) u_div (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (state != ST_RUN),
    .enable (state == ST_RUN),
    .tick   (div_tick)
  );

  // CE depends only on registered state and divider count.
  assign ce = ((state == ST_RUN) && div_tick)
            || (state == ST_STEP);

  assign step_edge = STEP && !step_prev;

  assign limit_hit = LIMIT_ON && ce
                   && (cycles_q == LIMIT_LAST);

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: begin
        if (RUN)
          state_d = ST_RUN;
        else if (step_edge)
          state_d = ST_STEP;
      end
      ST_RUN: begin
        if (ce && (HALT_REQ || limit_hit))
          state_d = ST_HALT;
        else if (!RUN)
          state_d = ST_IDLE;
      end
      ST_STEP: begin
        if (HALT_REQ || limit_hit)
          state_d = ST_HALT;
        else
          state_d = ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // History resets high so a STEP held through reset is not an edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      step_prev <= 1'b1;
      cycles_q  <= '0;
    end else begin
      state     <= state_d;
      step_prev <= STEP;
      if (ce)
        cycles_q <= cycles_q + 1'b1;
    end
  end

  assign CE     = ce;
  assign CYCLES = cycles_q;
  assign STATE  = state;
  assign HALTED = (state == ST_HALT);

endmodule

// File: tb/tb_cycle_controller.sv
// Directed bench for cycle_controller: DIV=1/3/4 instances share
// inputs; a MAX_CYCLES=5 instance covers CYCLE_LIMIT_EN builds.
module tb_cycle_controller;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic RUN = 1'b0;
  logic STEP = 1'b0;
  logic HALT_REQ = 1'b0;

  logic        ce1, ce3, ce4, ce5;
  logic [31:0] cyc1, cyc3, cyc4, cyc5;
  logic [1:0]  st1, st3, st4, st5;
  logic        h1, h3, h4, h5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  cycle_controller #(.DIV(1)) u1 (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP),
    .HALT_REQ(HALT_REQ), .CE(ce1), .CYCLES(cyc1),
    .STATE(st1), .HALTED(h1)
  );

  cycle_controller #(.DIV(3)) u3 (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP),
    .HALT_REQ(HALT_REQ), .CE(ce3), .CYCLES(cyc3),
    .STATE(st3), .HALTED(h3)
  );

  cycle_controller #(.DIV(4)) u4 (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP),
    .HALT_REQ(HALT_REQ), .CE(ce4), .CYCLES(cyc4),
    .STATE(st4), .HALTED(h4)
  );

  cycle_controller #(.DIV(1), .MAX_CYCLES(5)) u5 (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP),
    .HALT_REQ(HALT_REQ), .CE(ce5), .CYCLES(cyc5),
    .STATE(st5), .HALTED(h5)
  );

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    RUN = 1'b0;
    STEP = 1'b0;
    HALT_REQ = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    RUN = 1'b0;
    STEP = 1'b1;
    HALT_REQ = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (st1 !== 2'd0 || ce1 !== 1'b0 || cyc1 !== 32'd0
        || h1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state st=%0d ce=%b cyc=%0d h=%b want 0/0/0/0",
               st1, ce1, cyc1, h1);
    end
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (st1 !== 2'd0 || cyc1 !== 32'd0) begin
      n_bad++;
      $display("FAIL step_held_reset st=%0d cyc=%0d want 0/0",
               st1, cyc1);
    end
    STEP = 1'b0;
    tick();
  endtask

  task automatic test_run_div1();
    int ces;
    do_reset();
    RUN = 1'b1;
    ces = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (ce1 === 1'b1) ces++;
    end
    RUN = 1'b0;
    tick();
    n_cmp++;
    if (ces != 10) begin
      n_bad++;
      $display("FAIL div1_ce_count got %0d want 10", ces);
    end
    n_cmp++;
    if (ce1 !== 1'b0 || cyc1 !== 32'd10 || st1 !== 2'd0) begin
      n_bad++;
      $display("FAIL div1_end ce=%b cyc=%0d st=%0d want 0/10/0",
               ce1, cyc1, st1);
    end
  endtask

  task automatic test_run_div4();
    logic want;
    do_reset();
    RUN = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      want = (i % 4 == 0);
      n_cmp++;
      if (ce4 !== want) begin
        n_bad++;
        $display("FAIL div4_ce cycle=%0d got %b want %b",
                 i, ce4, want);
      end
    end
    RUN = 1'b0;
    tick();
    n_cmp++;
    if (cyc4 !== 32'd4 || st4 !== 2'd0) begin
      n_bad++;
      $display("FAIL div4_end cyc=%0d st=%0d want 4/0", cyc4, st4);
    end
  endtask

  task automatic test_run_drop();
    logic want;
    do_reset();
    RUN = 1'b1;
    tick();
    tick();
    RUN = 1'b0;
    tick();
    n_cmp++;
    if (st4 !== 2'd0 || ce4 !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_idle st=%0d ce=%b want 0/0", st4, ce4);
    end
    RUN = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      want = (i == 4);
      n_cmp++;
      if (ce4 !== want) begin
        n_bad++;
        $display("FAIL drop_restart cycle=%0d got %b want %b",
                 i, ce4, want);
      end
    end
    RUN = 1'b0;
    tick();
  endtask

  task automatic test_step();
    int ces;
    do_reset();
    tick();
    STEP = 1'b1;
    ces = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ce1 === 1'b1) ces++;
    end
    STEP = 1'b0;
    tick();
    n_cmp++;
    if (ces != 1 || cyc1 !== 32'd1) begin
      n_bad++;
      $display("FAIL step_once ces=%0d cyc=%0d want 1/1", ces, cyc1);
    end
    STEP = 1'b1;
    tick();
    n_cmp++;
    if (ce1 !== 1'b1 || st1 !== 2'd2) begin
      n_bad++;
      $display("FAIL step_second ce=%b st=%0d want 1/2", ce1, st1);
    end
    STEP = 1'b0;
    tick();
    n_cmp++;
    if (cyc1 !== 32'd2 || st1 !== 2'd0) begin
      n_bad++;
      $display("FAIL step_end cyc=%0d st=%0d want 2/0", cyc1, st1);
    end
  endtask

  task automatic test_run_step_priority();
    do_reset();
    tick();
    RUN = 1'b1;
    STEP = 1'b1;
    tick();
    n_cmp++;
    if (st1 !== 2'd1) begin
      n_bad++;
      $display("FAIL prio_run st=%0d want 1", st1);
    end
    RUN = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (st1 !== 2'd0 || cyc1 !== 32'd1) begin
      n_bad++;
      $display("FAIL prio_discard st=%0d cyc=%0d want 0/1",
               st1, cyc1);
    end
    STEP = 1'b0;
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    RUN = 1'b1;
    tick();
    tick();
    tick();
    HALT_REQ = 1'b1;
    RUN = 1'b0;
    tick();
    n_cmp++;
    if (st1 !== 2'd3 || h1 !== 1'b1 || cyc1 !== 32'd3
        || ce1 !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_enter st=%0d h=%b cyc=%0d ce=%b want 3/1/3/0",
               st1, h1, cyc1, ce1);
    end
    n_cmp++;
    if (st4 !== 2'd0) begin
      n_bad++;
      $display("FAIL halt_no_ce st=%0d want 0", st4);
    end
    HALT_REQ = 1'b0;
    RUN = 1'b1;
    tick();
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    tick();
    n_cmp++;
    if (st1 !== 2'd3 || cyc1 !== 32'd3 || ce1 !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_sticky st=%0d cyc=%0d ce=%b want 3/3/0",
               st1, cyc1, ce1);
    end
    do_reset();
    n_cmp++;
    if (st1 !== 2'd0 || cyc1 !== 32'd0 || h1 !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_reset st=%0d cyc=%0d h=%b want 0/0/0",
               st1, cyc1, h1);
    end
  endtask

  task automatic test_reset_mid();
    logic want;
    do_reset();
    RUN = 1'b1;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    n_cmp++;
    if (st3 !== 2'd0 || ce3 !== 1'b0 || cyc3 !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_reset st=%0d ce=%b cyc=%0d want 0/0/0",
               st3, ce3, cyc3);
    end
    RESET = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      want = (i == 3);
      n_cmp++;
      if (ce3 !== want) begin
        n_bad++;
        $display("FAIL mid_restart cycle=%0d got %b want %b",
                 i, ce3, want);
      end
    end
    do_reset();
    tick();
    STEP = 1'b1;
    RESET = 1'b1;
    tick();
    n_cmp++;
    if (st1 !== 2'd0 || ce1 !== 1'b0) begin
      n_bad++;
      $display("FAIL step_reset st=%0d ce=%b want 0/0", st1, ce1);
    end
    RESET = 1'b0;
    STEP = 1'b0;
  endtask

  task automatic test_cycle_limit();
`ifdef CYCLE_LIMIT_EN
    int ces;
    do_reset();
    RUN = 1'b1;
    ces = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ce5 === 1'b1) ces++;
    end
    n_cmp++;
    if (st5 !== 2'd3 || cyc5 !== 32'd5 || ces != 5) begin
      n_bad++;
      $display("FAIL limit st=%0d cyc=%0d ces=%0d want 3/5/5",
               st5, cyc5, ces);
    end
    RUN = 1'b0;
`else
    do_reset();
    tick();
    force u1.cycles_q = 32'hFFFF_FFFF;
    #1 release u1.cycles_q;
    tick();
    n_cmp++;
    if (cyc1 !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL wrap_preload got %h want ffffffff", cyc1);
    end
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    tick();
    n_cmp++;
    if (cyc1 !== 32'd0 || st1 !== 2'd0) begin
      n_bad++;
      $display("FAIL wrap cyc=%h st=%0d want 0/0", cyc1, st1);
    end
`endif
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_run_div1();
    test_run_div4();
    test_run_drop();
    test_step();
    test_run_step_priority();
    test_halt();
    test_reset_mid();
    test_cycle_limit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cycle_controller.md
CYCLE_CONTROLLER -- requirements
Module: cycle_controller

Interface
REQ-001 Parameter DIV, default 1: in RUN, CE is asserted once every DIV CLK cycles; legal range is 1..255.
REQ-002 Parameter MAX_CYCLES, default 1000: cycle limit, used only when CYCLE_LIMIT_EN is defined.
REQ-003 Port CLK, input, 1: the single free-running clock; all state changes on its rising edge.
REQ-004 Port RESET, input, 1: synchronous, active-high reset.
REQ-005 Port RUN, input, 1: level request for free-running execution.
REQ-006 Port STEP, input, 1: single-cycle request; only the rising edge is acted on.
REQ-007 Port HALT_REQ, input, 1: halt indication from the datapath (halt instruction executing).
REQ-008 Port CE, output, 1: clock-enable to the datapath; one datapath cycle per CLK cycle with CE=1.
REQ-009 Port CYCLES, output, 32: count of CLK cycles in which CE=1.
REQ-010 Port STATE, output, 2: current state encoding (IDLE=0, RUN=1, STEP=2, HALT=3).
REQ-011 Port HALTED, output, 1: high exactly when STATE=HALT.

Function
REQ-012 FSM states: IDLE, RUN, STEP, HALT, registered in a 2-bit state register.
REQ-013 IDLE with RUN=1 -> RUN.
REQ-014 IDLE with RUN=0 and a STEP rising edge (STEP=1, previous sampled STEP=0) -> STEP.
REQ-015 RUN and STEP simultaneous in IDLE: RUN wins; the STEP edge is discarded.
REQ-016 STEP lasts exactly one CLK cycle with CE=1, then -> IDLE, or -> HALT if HALT_REQ=1 in that cycle.
REQ-017 In RUN, a divider counter counts 0..DIV-1 and clears on entry to RUN; CE=1 only while in RUN with the counter at DIV-1.
REQ-018 With DIV=1, CE is continuously high in RUN, starting the first cycle after the edge that enters RUN.
REQ-019 RUN=0 while in RUN -> IDLE at the next edge; no further CE pulses; any partial divider count is discarded.
REQ-020 HALT_REQ is sampled only in cycles with CE=1; when sampled high -> HALT, and this overrides RUN=0 in the same cycle.
REQ-021 HALT is sticky: RUN, STEP and HALT_REQ are ignored; CE=0; exit only through RESET.
REQ-022 STEP edges arriving in RUN or HALT are ignored and are not queued.
REQ-023 CE is decoded only from registered state and the registered divider counter, with no input-to-CE combinational path.
REQ-024 CYCLES increments by 1 at each edge where CE=1, wrapping from 2^32-1 to 0.

Reset
REQ-025 RESET=1 at a rising edge sets STATE=IDLE, CE=0, CYCLES=0, HALTED=0, the divider counter to 0 and the STEP history register to 1.
REQ-026 Because the STEP history resets to 1, a STEP held high through reset does not cause a step.
REQ-027 RESET takes priority over every transition, including mid-RUN and mid-STEP; no CE is issued in the reset cycle.

Configuration
REQ-028 Macro CYCLE_LIMIT_EN is the only compile-time feature switch.
REQ-029 With CYCLE_LIMIT_EN defined: at an edge where CE=1 and CYCLES=MAX_CYCLES-1, the block goes to HALT; CYCLES ends at MAX_CYCLES.
REQ-030 Without CYCLE_LIMIT_EN: the block has no cycle limit, MAX_CYCLES has no effect, and CYCLES wraps per REQ-024.

Structure
REQ-031 Shared package cycle_ctrl_pkg holds the state encodings, CYCLES_W=32 and the DIV range limits.
REQ-032 Sub-module clk_divider (ports CLK, RESET, clear, enable, tick) implements REQ-017.
REQ-033 cycle_controller instantiates clk_divider once, feeds it from the FSM, and uses its tick output to generate CE.

Verification
REQ-034 DIV=1: RESET for 2 cycles, then RUN=1 for 10 cycles, then RUN=0 -> CE high for exactly 10 cycles, CYCLES=10, STATE=IDLE.
REQ-035 DIV=4: RUN=1 held for 16 cycles -> CE pulses on cycles 4, 8, 12 and 16 after entry; CYCLES=4.
REQ-036 STEP held high for 5 cycles in IDLE -> exactly one CE pulse and CYCLES=1; a second STEP edge gives CYCLES=2.
REQ-037 RUN with HALT_REQ=1 coincident with the 3rd CE, and RUN dropped in the same cycle -> STATE=HALT, HALTED=1, CYCLES=3, CE=0 thereafter; a later STEP has no effect; RESET returns to IDLE with CYCLES=0.
REQ-038 CYCLE_LIMIT_EN defined, MAX_CYCLES=5, RUN=1 -> HALT after the 5th CE, CYCLES=5; CYCLES preloaded via force to 0xFFFFFFFF without the macro, one CE -> CYCLES=0.
REQ-039 RESET asserted during RUN, DIV=3, counter at 1 -> next cycle STATE=IDLE, CE=0, CYCLES=0; RUN held high -> first CE 3 cycles after reset release.
